pll_reset_seq: RTL and testbench

Lock-qualified reset sequencer sitting directly downstream of the PLL core. It runs on the PLL's global output clock, synchronizes and debounces the PLL lock flag, and releases two staged active-low resets: core logic first, then the bus/bridge side. On sustained lock loss it re-asserts both resets and re-qualifies lock.

---
 rtl/pll_reset_seq_pkg.sv | 5 +
 rtl/pll_reset_seq_if.sv | 30 +++
 rtl/pll_reset_seq_bit_sync.sv | 23 ++
 rtl/pll_reset_seq.sv | 107 ++++++++++
 tb/tb_pll_reset_seq.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/pll_reset_seq_pkg.sv
// pll_reset_pkg: state encoding and widths shared by pll_reset_seq and its interface.
package pll_reset_pkg;
    typedef enum logic [1:0] {WAIT_LOCK, QUALIFY, RELEASE, RUN} state_e;
    localparam int LOSS_CNT_W = 8;
endpackage

// File: rtl/pll_reset_seq_if.sv
// pll_reset_seq_if: PLL lock input and staged reset outputs of pll_reset_seq.
// lock_loss_count exists only when PLL_RESET_SEQ_STATUS_EN is defined.
interface pll_reset_seq_if;
    import pll_reset_pkg::*;
    logic locked_in;
    logic core_resetb;
    logic bus_resetb;
    logic ready;
`ifdef PLL_RESET_SEQ_STATUS_EN
    logic [LOSS_CNT_W-1:0] lock_loss_count;
`endif
    modport master (
        input  locked_in,
        output core_resetb,
        output bus_resetb,
        output ready
`ifdef PLL_RESET_SEQ_STATUS_EN
        , output lock_loss_count
`endif
    );
    modport slave (
        output locked_in,
        input  core_resetb,
        input  bus_resetb,
        input  ready
`ifdef PLL_RESET_SEQ_STATUS_EN
        , input lock_loss_count
`endif
    );
endinterface

// File: rtl/pll_reset_seq_bit_sync.sv
// bit_sync: two-flop synchronizer with synchronous active-low clear.
module bit_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta_q, meta_d, sync_q, sync_d;
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end
    assign q = sync_q;
endmodule

// File: rtl/pll_reset_seq.sv
// pll_reset_seq: lock-qualified reset sequencer releasing core reset, then bus reset.
// Define PLL_RESET_SEQ_STATUS_EN to add the saturating lock_loss_count output.
module pll_reset_seq
    import pll_reset_pkg::*;
#(
    parameter int LOCK_CYCLES    = 1024,
    parameter int STAGGER_CYCLES = 16,
    parameter int GLITCH_CYCLES  = 4
) (
    input  logic            clock_in,
    input  logic            resetb,
    pll_reset_seq_if.master bus
);
    localparam int MAX_LS = (LOCK_CYCLES > STAGGER_CYCLES) ? LOCK_CYCLES : STAGGER_CYCLES;
    localparam int MAX_C  = (MAX_LS > GLITCH_CYCLES) ? MAX_LS : GLITCH_CYCLES;
    localparam int CW     = $clog2(MAX_C) + 1;
    localparam logic [CW-1:0] LOCK_END    = CW'(LOCK_CYCLES - 1);
    localparam logic [CW-1:0] STAGGER_END = CW'(STAGGER_CYCLES - 1);
    localparam logic [CW-1:0] GLITCH_END  = CW'(GLITCH_CYCLES);

    logic          lock_s;
    logic          lock_lost;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] glitch_q, glitch_d;
    logic          core_q, core_d;
    logic          run_q, run_d;

    bit_sync u_lock_sync (
        .clk   (clock_in),
        .rst_n (resetb),
        .d     (bus.locked_in),
        .q     (lock_s)
    );

    always_ff @(posedge clock_in) begin
        if (!resetb) begin
            state_q  <= WAIT_LOCK;
            cnt_q    <= '0;
            glitch_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            glitch_q <= glitch_d;
        end
    end

    // Lock loss only counts once the core side is out of reset.
    always_comb begin
        glitch_d  = ((state_q == RELEASE || state_q == RUN) && !lock_s) ? glitch_q + 1'b1 : '0;
        lock_lost = glitch_d == GLITCH_END;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        case (state_q)
            WAIT_LOCK: begin
                cnt_d = lock_s ? CW'(1) : '0;
                if (lock_s) state_d = QUALIFY;
            end
            QUALIFY: if (!lock_s || cnt_q == LOCK_END) begin
                state_d = lock_s ? RELEASE : WAIT_LOCK;
                cnt_d   = '0;
            end
            RELEASE: if (lock_lost || cnt_q == STAGGER_END) begin
                state_d = lock_lost ? WAIT_LOCK : RUN;
                cnt_d   = '0;
            end
            default: begin
                cnt_d = '0;
                if (lock_lost) state_d = WAIT_LOCK;
            end
        endcase
    end

    always_comb begin
        core_d = state_q == RELEASE || state_q == RUN;
        run_d  = state_q == RUN;
    end

    always_ff @(posedge clock_in) begin
        if (!resetb) begin
            core_q <= 1'b0;
            run_q  <= 1'b0;
        end else begin
            core_q <= core_d;
            run_q  <= run_d;
        end
    end

    assign bus.core_resetb = core_q;
    assign bus.bus_resetb  = run_q;
    assign bus.ready       = run_q;

`ifdef PLL_RESET_SEQ_STATUS_EN
    logic [LOSS_CNT_W-1:0] loss_cnt_q, loss_cnt_d;
    always_comb begin
        loss_cnt_d = (lock_lost && loss_cnt_q != '1) ? loss_cnt_q + 1'b1 : loss_cnt_q;
    end
    always_ff @(posedge clock_in) begin
        if (!resetb) loss_cnt_q <= '0;
        else         loss_cnt_q <= loss_cnt_d;
    end
    assign bus.lock_loss_count = loss_cnt_q;
`endif
endmodule

// File: tb/tb_pll_reset_seq.sv
// tb_pll_reset_seq: scoreboard bench for pll_reset_seq with directed and random lock patterns.
module tb_pll_reset_seq;
    localparam int LOCK = 8;
    localparam int STAG = 4;
    localparam int GL   = 3;

    logic clock_in = 1'b0;
    logic resetb   = 1'b0;
    logic locked_in = 1'b0;
    int   checks = 0;
    int   errors = 0;

    pll_reset_seq_if bus_if ();
    assign bus_if.locked_in = locked_in;

    pll_reset_seq #(
        .LOCK_CYCLES    (LOCK),
        .STAGGER_CYCLES (STAG),
        .GLITCH_CYCLES  (GL)
    ) dut (
        .clock_in (clock_in),
        .resetb   (resetb),
        .bus      (bus_if)
    );

    always #5 clock_in = ~clock_in;

    typedef struct {
        logic       core;
        logic       bus;
        logic [7:0] cnt;
    } exp_t;
    exp_t sb[$];

    // Reference: lock_s is locked_in delayed two edges; release after LOCK
    // consecutive high samples, bus follows STAG edges later, GL lows drop both.
    bit m_s1, m_s2, m_on;
    int m_streak, m_age, m_lows, m_losses;

    task automatic model_step();
        exp_t e;
        bit   ls;
        if (!resetb) begin
            m_s1 = 0; m_s2 = 0; m_on = 0;
            m_streak = 0; m_age = 0; m_lows = 0; m_losses = 0;
            e.core = 0; e.bus = 0;
        end else begin
            ls = m_s2; m_s2 = m_s1; m_s1 = locked_in;
            e.core = m_on;
            e.bus  = m_on && m_age >= STAG;
            if (!m_on) begin
                m_streak = ls ? m_streak + 1 : 0;
                if (m_streak == LOCK) begin
                    m_on = 1; m_age = 0; m_lows = 0; m_streak = 0;
                end
            end else begin
                m_lows = ls ? 0 : m_lows + 1;
                if (m_lows == GL) begin
                    m_on = 0;
                    m_losses = (m_losses < 255) ? m_losses + 1 : 255;
                end else if (m_age < 1000) begin
                    m_age++;
                end
            end
        end
        e.cnt = m_losses[7:0];
        sb.push_back(e);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic rb, input logic lk);
        @(negedge clock_in);
        resetb = rb;
        locked_in = lk;
        @(posedge clock_in);
        model_step();
        #1;
    endtask

    // Edge index (0 = first edge with the new lk) at which each reset reaches lvl.
    task automatic measure(input string name, input logic lk, input logic lvl,
                           input int want_core, input int want_bus);
        int core_at = -1;
        int bus_at  = -1;
        for (int i = 0; i < 40 && bus_at < 0; i++) begin
            step(1'b1, lk);
            if (core_at < 0 && bus_if.core_resetb == lvl) core_at = i;
            if (bus_at < 0 && bus_if.bus_resetb == lvl) bus_at = i;
        end
        chk({name, " core_resetb edge"}, core_at, want_core);
        chk({name, " bus_resetb edge"}, bus_at, want_bus);
    endtask

    task automatic chk_cnt(input string name, input int want);
`ifdef PLL_RESET_SEQ_STATUS_EN
        chk(name, int'(bus_if.lock_loss_count), want);
`endif
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clock_in);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("sb core_resetb", int'(bus_if.core_resetb), int'(e.core));
                chk("sb bus_resetb", int'(bus_if.bus_resetb), int'(e.bus));
                chk("sb ready", int'(bus_if.ready), int'(e.bus));
`ifdef PLL_RESET_SEQ_STATUS_EN
                chk("sb lock_loss_count", int'(bus_if.lock_loss_count), int'(e.cnt));
`endif
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        logic lk, rb;
        int   len;
        repeat (3) step(1'b0, 1'b0);
        chk("reset core_resetb", int'(bus_if.core_resetb), 0);
        chk("reset bus_resetb", int'(bus_if.bus_resetb), 0);
        chk("reset ready", int'(bus_if.ready), 0);
        chk_cnt("reset lock_loss_count", 0);
        repeat (3) step(1'b1, 1'b0);
        measure("clean lock", 1'b1, 1'b1, LOCK + 2, LOCK + 2 + STAG);
        repeat (5) step(1'b1, 1'b1);
        repeat (2) step(1'b1, 1'b0);
        repeat (6) step(1'b1, 1'b1);
        chk("dropout core_resetb", int'(bus_if.core_resetb), 1);
        chk("dropout ready", int'(bus_if.ready), 1);
        chk_cnt("dropout lock_loss_count", 0);
        measure("lock loss", 1'b0, 1'b0, GL + 2, GL + 2);
        chk_cnt("loss lock_loss_count", 1);
        repeat (3) step(1'b1, 1'b0);
        measure("relock", 1'b1, 1'b1, LOCK + 2, LOCK + 2 + STAG);
        repeat (8) step(1'b1, 1'b0);
        repeat (5) step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        measure("qualify glitch", 1'b1, 1'b1, LOCK + 2, LOCK + 2 + STAG);
        repeat (8) step(1'b1, 1'b0);
        repeat (LOCK + 3) step(1'b1, 1'b1);
        chk("pre-reset core_resetb", int'(bus_if.core_resetb), 1);
        chk("pre-reset bus_resetb", int'(bus_if.bus_resetb), 0);
        step(1'b0, 1'b1);
        chk("mid-release core_resetb", int'(bus_if.core_resetb), 0);
        chk("mid-release bus_resetb", int'(bus_if.bus_resetb), 0);
        chk("mid-release ready", int'(bus_if.ready), 0);
        chk_cnt("mid-release lock_loss_count", 0);
        measure("post reset", 1'b1, 1'b1, LOCK + 2, LOCK + 2 + STAG);
        for (int r = 0; r < 150; r++) begin
            lk  = $urandom_range(0, 3) != 0;
            len = lk ? $urandom_range(1, 30) : $urandom_range(1, 5);
            repeat (len) begin
                rb = $urandom_range(0, 99) != 0;
                step(rb, lk);
            end
        end
        repeat (300) begin
            repeat (LOCK + STAG + 4) step(1'b1, 1'b1);
            repeat (GL + 3) step(1'b1, 1'b0);
        end
        chk("saturated core_resetb", int'(bus_if.core_resetb), 0);
        chk_cnt("saturated lock_loss_count", 255);
        repeat (2) @(negedge clock_in);
        chk("scoreboard drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
